// File: rtl/pes_prod_acc.sv
// Signed product accumulator: sums a programmed number of multiplier results
// with saturation, then holds the result until the downstream accepts it.
module pes_prod_acc #(
  parameter int unsigned ACC_W = 12
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    Go,
  input  logic [3:0]              Len,
  input  logic                    Done,
  input  logic [6:0]              Product,
  input  logic                    Ready,
  output logic signed [ACC_W-1:0] Acc,
  output logic                    Valid,
  output logic                    Busy,
  output logic                    Ovf,
  output logic                    Lost
);

  localparam int unsigned CNT_W = 5;
  localparam int unsigned EXT_W = ACC_W - 7;
  localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_done_d;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_len_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_acc_nxt;
  logic [ACC_W-1:0] w_prod_ext;
  logic [ACC_W-1:0] w_acc_sat;
  logic [ACC_W:0]   w_sum;
  logic             r_valid;
  logic             r_busy;
  logic             r_ovf;
  logic             r_lost;
  logic             w_ovf_nxt;
  logic             w_lost_nxt;
  logic             w_evt;
  logic             w_sat;

  // Rising edge of Done is one product, however long Done stays high
  assign w_evt      = Done & ~r_done_d;
  assign w_prod_ext = {{EXT_W{Product[6]}}, Product};
  assign w_sum      = {r_acc[ACC_W-1], r_acc} + {w_prod_ext[ACC_W-1], w_prod_ext};
  assign w_sat      = w_sum[ACC_W] ^ w_sum[ACC_W-1];
  assign w_acc_sat  = !w_sat ? w_sum[ACC_W-1:0] : (w_sum[ACC_W] ? SAT_MIN : SAT_MAX);
  assign w_cnt_inc  = r_cnt + CNT_W'(1);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_ovf_nxt   = r_ovf;
    w_cnt_nxt   = r_cnt;
    w_len_nxt   = r_len;
    w_lost_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A product coinciding with Go is dropped, the run starts clean
        w_lost_nxt = w_evt;
        if (Go) begin
          w_len_nxt   = (Len == 4'd0) ? CNT_W'(16) : CNT_W'(Len);
          w_acc_nxt   = '0;
          w_ovf_nxt   = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (w_evt) begin
          w_acc_nxt = w_acc_sat;
          w_ovf_nxt = r_ovf | w_sat;
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == r_len) begin
            w_state_nxt = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        w_lost_nxt = w_evt;
        if (Ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_done_d <= 1'b0;
      r_acc    <= '0;
      r_ovf    <= 1'b0;
      r_cnt    <= '0;
      r_len    <= '0;
      r_lost   <= 1'b0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_done_d <= Done;
      r_acc    <= w_acc_nxt;
      r_ovf    <= w_ovf_nxt;
      r_cnt    <= w_cnt_nxt;
      r_len    <= w_len_nxt;
      r_lost   <= w_lost_nxt;
      r_valid  <= (w_state_nxt == S_HOLD);
      r_busy   <= (w_state_nxt == S_ACCUM);
    end
  end

  assign Acc   = r_acc;
  assign Valid = r_valid;
  assign Busy  = r_busy;
  assign Ovf   = r_ovf;
  assign Lost  = r_lost;

endmodule

// File: tb/tb_pes_prod_acc.sv
// Bench for pes_prod_acc: a 12-bit and an 8-bit instance share stimulus and are
// checked against saturating-sum arithmetic computed here.
module tb_pes_prod_acc;

  logic        CLK = 1'b0;
  logic        RST;
  logic        Go;
  logic [3:0]  Len;
  logic        Done;
  logic [6:0]  Product;
  logic        Ready;

  logic signed [11:0] acc12;
  logic signed [7:0]  acc8;
  logic v12, b12, o12, l12;
  logic v8, b8, o8, l8;

  int n_checks;
  int n_fail;

  always #5 CLK = ~CLK;

  pes_prod_acc #(.ACC_W(12)) u_dut12 (
    .CLK(CLK), .RST(RST), .Go(Go), .Len(Len), .Done(Done), .Product(Product),
    .Ready(Ready), .Acc(acc12), .Valid(v12), .Busy(b12), .Ovf(o12), .Lost(l12)
  );

  pes_prod_acc #(.ACC_W(8)) u_dut8 (
    .CLK(CLK), .RST(RST), .Go(Go), .Len(Len), .Done(Done), .Product(Product),
    .Ready(Ready), .Acc(acc8), .Valid(v8), .Busy(b8), .Ovf(o8), .Lost(l8)
  );

  function automatic int sx7(input logic [6:0] p);
    return p[6] ? int'(p) - 128 : int'(p);
  endfunction

  function automatic int sat_add(input int a, input int p, input int w);
    int hi;
    int lo;
    int s;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    s  = a + p;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_run(input logic [3:0] l);
    Go  = 1'b1;
    Len = l;
    tick();
    Go  = 1'b0;
    Len = 4'($urandom);
  endtask

  // One clean Done pulse; returns just after the edge that registers the event
  task automatic pulse(input logic [6:0] p);
    Done = 1'b0;
    tick();
    Done    = 1'b1;
    Product = p;
    tick();
    Done    = 1'b0;
    Product = 7'($urandom);
  endtask

  task automatic release_hold();
    Ready = 1'b1;
    tick();
    Ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    n_checks++;
    if (acc12 !== 12'd0 || acc8 !== 8'd0) begin
      n_fail++; $display("FAIL reset_acc: got %0d/%0d expected 0/0", acc12, acc8);
    end
    n_checks++;
    if ({v12, b12, o12, l12, v8, b8, o8, l8} !== 8'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b%b%b%b %b%b%b%b expected all 0",
                         v12, b12, o12, l12, v8, b8, o8, l8);
    end
    RST = 1'b0;
    tick();
    pulse(7'h11);
    n_checks++;
    if (acc12 !== 12'd0 || acc8 !== 8'd0) begin
      n_fail++; $display("FAIL idle_product_acc: got %0d/%0d expected 0/0", acc12, acc8);
    end
    n_checks++;
    if ({v12, b12, o12, l12} !== 4'b0001 || {v8, b8, o8, l8} !== 4'b0001) begin
      n_fail++; $display("FAIL idle_product_lost: got %b%b%b%b/%b%b%b%b expected 0001/0001",
                         v12, b12, o12, l12, v8, b8, o8, l8);
    end
  endtask

  task automatic test_basic();
    logic [6:0] pv [3];
    int a12;
    int a8;
    pv = '{7'h0A, 7'h7B, 7'h3F};
    a12 = 0;
    a8  = 0;
    start_run(4'd3);
    n_checks++;
    if ({v12, b12, o12, l12} !== 4'b0100 || acc12 !== 12'd0) begin
      n_fail++; $display("FAIL basic_start: got flags %b%b%b%b acc %0d expected 0100 acc 0",
                         v12, b12, o12, l12, acc12);
    end
    for (int k = 0; k < 3; k++) begin
      pulse(pv[k]);
      a12 = sat_add(a12, sx7(pv[k]), 12);
      a8  = sat_add(a8, sx7(pv[k]), 8);
      n_checks++;
      if (acc12 !== 12'(a12) || acc8 !== 8'(a8)) begin
        n_fail++; $display("FAIL basic_acc step %0d: got %0d/%0d expected %0d/%0d",
                           k, acc12, acc8, a12, a8);
      end
      n_checks++;
      if ({v12, b12, o12, l12} !== {k == 2, k != 2, 2'b00}) begin
        n_fail++; $display("FAIL basic_flags step %0d: got %b%b%b%b expected %b%b00",
                           k, v12, b12, o12, l12, k == 2, k != 2);
      end
    end
    n_checks++;
    if (acc12 !== 12'h044) begin
      n_fail++; $display("FAIL basic_final: got %h expected 044", acc12);
    end
    release_hold();
    n_checks++;
    if ({v12, b12, v8, b8} !== 4'b0000 || acc12 !== 12'd68) begin
      n_fail++; $display("FAIL basic_release: got v%b b%b acc %0d expected v0 b0 acc 68",
                         v12, b12, acc12);
    end
  endtask

  task automatic test_saturate();
    int a12;
    int a8;
    bit ov8;
    a12 = 0;
    a8  = 0;
    ov8 = 1'b0;
    start_run(4'd3);
    for (int k = 0; k < 3; k++) begin
      pulse(7'h3F);
      ov8 = ov8 | (a8 + 63 != sat_add(a8, 63, 8));
      a12 = sat_add(a12, 63, 12);
      a8  = sat_add(a8, 63, 8);
      n_checks++;
      if (acc8 !== 8'(a8) || acc12 !== 12'(a12)) begin
        n_fail++; $display("FAIL sat_acc step %0d: got %0d/%0d expected %0d/%0d",
                           k, acc8, acc12, a8, a12);
      end
      n_checks++;
      if ({v8, b8, o8, l8} !== {k == 2, k != 2, ov8, 1'b0} || o12 !== 1'b0) begin
        n_fail++; $display("FAIL sat_flags step %0d: got %b%b%b%b ovf12 %b expected %b%b%b0 ovf12 0",
                           k, v8, b8, o8, l8, o12, k == 2, k != 2, ov8);
      end
    end
    n_checks++;
    if (acc8 !== 8'sd127 || o8 !== 1'b1) begin
      n_fail++; $display("FAIL sat_final: got %0d ovf %b expected 127 ovf 1", acc8, o8);
    end
    release_hold();
  endtask

  task automatic test_done_held();
    start_run(4'd2);
    Done = 1'b0;
    tick();
    Product = 7'h11;
    Done    = 1'b1;
    repeat (3) tick();
    Done = 1'b0;
    repeat (2) tick();
    n_checks++;
    if (acc12 !== 12'd17 || acc8 !== 8'd17 || {v12, b12} !== 2'b01) begin
      n_fail++; $display("FAIL held_once: got acc %0d/%0d v%b b%b expected 17/17 v0 b1",
                         acc12, acc8, v12, b12);
    end
    pulse(7'h02);
    n_checks++;
    if (acc12 !== 12'd19 || {v12, b12, v8, b8} !== 4'b1010) begin
      n_fail++; $display("FAIL held_finish: got acc %0d v%b b%b expected 19 v1 b0",
                         acc12, v12, b12);
    end
    release_hold();
  endtask

  task automatic test_hold();
    start_run(4'd1);
    pulse(7'h05);
    n_checks++;
    if (acc12 !== 12'd5 || {v12, b12, o12, l12} !== 4'b1000) begin
      n_fail++; $display("FAIL hold_enter: got acc %0d flags %b%b%b%b expected 5 1000",
                         acc12, v12, b12, o12, l12);
    end
    Go  = 1'b1;
    Len = 4'd2;
    for (int i = 0; i < 5; i++) begin
      Done    = (i == 1);
      Product = 7'h3F;
      tick();
      n_checks++;
      if (acc12 !== 12'd5 || acc8 !== 8'd5 ||
          {v12, b12, o12, l12} !== {3'b100, i == 1} || {v8, b8, l8} !== {2'b10, i == 1}) begin
        n_fail++; $display("FAIL hold_stable cycle %0d: got acc %0d/%0d flags %b%b%b%b expected 5 100%b",
                           i, acc12, acc8, v12, b12, o12, l12, i == 1);
      end
    end
    Go   = 1'b0;
    Done = 1'b0;
    release_hold();
    n_checks++;
    if ({v12, b12, o12, l12} !== 4'b0000 || acc12 !== 12'd5) begin
      n_fail++; $display("FAIL hold_release: got flags %b%b%b%b acc %0d expected 0000 acc 5",
                         v12, b12, o12, l12, acc12);
    end
    tick();
    n_checks++;
    if ({v12, b12, v8, b8} !== 4'b0000) begin
      n_fail++; $display("FAIL hold_stay_idle: got v%b b%b expected v0 b0", v12, b12);
    end
  endtask

  task automatic test_len16();
    int a12;
    int a8;
    bit ov12;
    bit ov8;
    a12 = 0; a8 = 0; ov12 = 1'b0; ov8 = 1'b0;
    start_run(4'd0);
    for (int k = 0; k < 16; k++) begin
      Go  = (k == 4);
      Len = 4'd1;
      pulse(7'h40);
      Go = 1'b0;
      ov12 = ov12 | (a12 - 64 != sat_add(a12, -64, 12));
      ov8  = ov8 | (a8 - 64 != sat_add(a8, -64, 8));
      a12  = sat_add(a12, -64, 12);
      a8   = sat_add(a8, -64, 8);
      n_checks++;
      if (acc12 !== 12'(a12) || acc8 !== 8'(a8)) begin
        n_fail++; $display("FAIL len16_acc step %0d: got %0d/%0d expected %0d/%0d",
                           k, acc12, acc8, a12, a8);
      end
      n_checks++;
      if ({v12, b12, o12} !== {k == 15, k != 15, ov12} || {v8, b8, o8} !== {k == 15, k != 15, ov8}) begin
        n_fail++; $display("FAIL len16_flags step %0d: got %b%b%b/%b%b%b expected %b%b%b/%b%b%b",
                           k, v12, b12, o12, v8, b8, o8, k == 15, k != 15, ov12, k == 15, k != 15, ov8);
      end
    end
    n_checks++;
    if (acc12 !== 12'hC00 || o12 !== 1'b0) begin
      n_fail++; $display("FAIL len16_final: got %h ovf %b expected c00 ovf 0", acc12, o12);
    end
    release_hold();
  endtask

  task automatic test_mid_reset();
    start_run(4'd3);
    pulse(7'($urandom));
    pulse(7'($urandom));
    #2;
    RST = 1'b1;
    #1;
    n_checks++;
    if (acc12 !== 12'd0 || acc8 !== 8'd0 || {v12, b12, o12, l12, v8, b8, o8, l8} !== 8'b0) begin
      n_fail++; $display("FAIL async_reset: got acc %0d/%0d flags %b%b%b%b expected 0 0000",
                         acc12, acc8, v12, b12, o12, l12);
    end
    tick();
    RST = 1'b0;
    tick();
    n_checks++;
    if ({b12, v12} !== 2'b00) begin
      n_fail++; $display("FAIL reset_no_resume: got b%b v%b expected b0 v0", b12, v12);
    end
    start_run(4'd1);
    pulse(7'h05);
    n_checks++;
    if (acc12 !== 12'd5 || acc8 !== 8'd5 || {v12, b12, v8, b8} !== 4'b1010) begin
      n_fail++; $display("FAIL post_reset_run: got acc %0d/%0d v%b b%b expected 5 v1 b0",
                         acc12, acc8, v12, b12);
    end
    release_hold();
  endtask

  task automatic test_random();
    for (int r = 0; r < 12; r++) begin
      logic [3:0] l;
      int n;
      int a12;
      int a8;
      bit ov12;
      bit ov8;
      l = 4'($urandom_range(0, 15));
      n = (l == 4'd0) ? 16 : int'(l);
      a12 = 0; a8 = 0; ov12 = 1'b0; ov8 = 1'b0;
      start_run(l);
      for (int k = 0; k < n; k++) begin
        logic [6:0] p;
        p = 7'($urandom);
        pulse(p);
        ov12 = ov12 | (a12 + sx7(p) != sat_add(a12, sx7(p), 12));
        ov8  = ov8 | (a8 + sx7(p) != sat_add(a8, sx7(p), 8));
        a12  = sat_add(a12, sx7(p), 12);
        a8   = sat_add(a8, sx7(p), 8);
        n_checks++;
        if (acc12 !== 12'(a12) || acc8 !== 8'(a8)) begin
          n_fail++; $display("FAIL rand_acc run %0d step %0d: got %0d/%0d expected %0d/%0d",
                             r, k, acc12, acc8, a12, a8);
        end
      end
      n_checks++;
      if ({v12, b12, o12, l12} !== {2'b10, ov12, 1'b0} || {v8, b8, o8, l8} !== {2'b10, ov8, 1'b0}) begin
        n_fail++; $display("FAIL rand_end run %0d: got %b%b%b%b/%b%b%b%b expected 10%b0/10%b0",
                           r, v12, b12, o12, l12, v8, b8, o8, l8, ov12, ov8);
      end
      repeat ($urandom_range(0, 3)) tick();
      release_hold();
      n_checks++;
      if ({v12, b12, o12} !== {2'b00, ov12} || acc8 !== 8'(a8)) begin
        n_fail++; $display("FAIL rand_idle run %0d: got %b%b%b acc8 %0d expected 00%b acc8 %0d",
                           r, v12, b12, o12, acc8, ov12, a8);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    RST      = 1'b1;
    Go       = 1'b0;
    Len      = 4'd0;
    Done     = 1'b0;
    Product  = 7'd0;
    Ready    = 1'b0;
    test_reset();
    test_basic();
    test_saturate();
    test_done_held();
    test_hold();
    test_len16();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pes_prod_acc.md
PES_PROD_ACC -- requirements
Module: pes_prod_acc

Interface
REQ-001 The block SHALL take parameter ACC_W, default 12, accumulator width in bits (legal 8..16).
REQ-002 The block SHALL have port CLK  input  1  single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port Go  input  1  start of a new accumulation run; sampled only in IDLE.
REQ-005 The block SHALL have port Len  input  4  number of products per run; sampled with Go; 0 means 16.
REQ-006 The block SHALL have port Done  input  1  multiplier completion flag from the upstream 4x4 signed multiplier.
REQ-007 The block SHALL have port Product  input  7  two's-complement product from the multiplier, valid while Done=1.
REQ-008 The block SHALL have port Ready  input  1  downstream accepts the result when high.
REQ-009 The block SHALL have port Acc  output  ACC_W  signed running or final sum.
REQ-010 The block SHALL have port Valid  output  1  Acc holds a completed run result.
REQ-011 The block SHALL have port Busy  output  1  run in progress (ACCUM state).
REQ-012 The block SHALL have port Ovf  output  1  sticky saturation flag for the current run.
REQ-013 The block SHALL have port Lost  output  1  one-cycle pulse: a Done edge arrived outside ACCUM and was dropped.

Function
REQ-014 The block SHALL implement FSM states IDLE, ACCUM and HOLD, all registered.
REQ-015 The block SHALL register Done into Done_d each cycle; a product event SHALL be Done=1 and Done_d=0, so a multi-cycle Done counts once.
REQ-016 In IDLE, Go=1 SHALL load the run length (Len, 0 mapped to 16), clear Acc, Ovf and the product counter, and move to ACCUM on the same edge.
REQ-017 In ACCUM, each product event SHALL sign-extend Product[6:0] to ACC_W bits and add it to Acc on that edge, incrementing the counter.
REQ-018 Addition SHALL saturate to +(2^(ACC_W-1)-1) or -2^(ACC_W-1); any saturation SHALL set Ovf, which stays set until the next accepted Go.
REQ-019 The event that brings the counter to the run length SHALL update Acc and move to HOLD on the same edge; Valid SHALL be 1 from that edge.
REQ-020 In HOLD, Acc, Ovf and Valid SHALL be stable; Valid=1 and Ready=1 on an edge SHALL move to IDLE with Valid=0 after that edge.
REQ-021 In IDLE, Acc and Ovf SHALL keep the last run's values until the next accepted Go.
REQ-022 Go SHALL be ignored in ACCUM and HOLD, and Len SHALL be ignored except on an accepted Go.
REQ-023 A product event in IDLE or HOLD SHALL leave Acc unchanged and pulse Lost high for exactly the following cycle.
REQ-024 When Go and a product event coincide in IDLE, the block SHALL accept Go and SHALL NOT count the product.
REQ-025 Busy SHALL equal 1 exactly while the state is ACCUM.

Reset
REQ-026 RST=1 SHALL asynchronously force IDLE, Acc=0, Valid=0, Busy=0, Ovf=0, Lost=0, counter=0 and Done_d=0, including mid-run.
REQ-027 After RST deasserts, the first operation SHALL be an accepted Go; no partial run SHALL resume.

Verification
REQ-028 The bench SHALL cover this case: Go with Len=3, then products 7'h0A, 7'h7B, 7'h3F -> Acc=12'h044 (68), Valid=1 on the third event edge, Ovf=0, Busy=0.
REQ-029 The bench SHALL cover this case: ACC_W=8, Go with Len=3, products 7'h3F x3 -> Acc steps 63, 126, then 127 saturated; Ovf=1 and Valid=1.
REQ-030 The bench SHALL cover this case: Done held high for 3 cycles once during ACCUM with Len=2 -> counted once; still in ACCUM with Busy=1.
REQ-031 The bench SHALL cover this case: HOLD with Ready=0 for 5 cycles plus one Done pulse -> Acc and Valid unchanged, one Lost pulse; Ready=1 -> IDLE, Valid=0 next cycle.
REQ-032 The bench SHALL cover this case: Go with Len=0 and 16 products of 7'h40 (-64) -> Acc=12'hC00 (-1024), Ovf=0; a Go issued during the run is ignored.
REQ-033 The bench SHALL cover this case: RST pulsed after 2 of 3 products -> all outputs 0 and IDLE immediately; a later Go with Len=1 and product 7'h05 -> Acc=5, Valid=1.
